// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Requester-side and memory-side bundle for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int NCH = 3,
    parameter int AW  = 25,
    parameter int DW  = 8
);
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    we;
    logic [NCH*AW-1:0] addr;
    logic [NCH*DW-1:0] wdata;
    logic [NCH-1:0]    ack;
    logic [DW-1:0]     rdata;
    logic [NCH-1:0]    grant;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_din;
    logic              mem_we;
    logic              mem_re;
    logic [DW-1:0]     mem_dout;

    // master is the environment: the requesters plus the memory returning mem_dout
    modport master (
        output req, we, addr, wdata, mem_dout,
        input  ack, rdata, grant, mem_addr, mem_din, mem_we, mem_re
    );

    modport slave (
        input  req, we, addr, wdata, mem_dout,
        output ack, rdata, grant, mem_addr, mem_din, mem_we, mem_re
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : N-channel request/ack arbiter onto one single-port memory.
//            Define MEM_ARB_RR_EN for round-robin; otherwise fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int NCH    = 3,
    parameter int AW     = 25,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  wire logic         F14Mx2,
    input  wire logic         reset,
    mem_port_arbiter_if.slave bus
);
    localparam int                 c_idx_w    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [1:0]         c_cnt_init = 2'(RD_LAT - 1);
    localparam logic [c_idx_w-1:0] c_last     = c_idx_w'(NCH - 1);
    localparam logic [c_idx_w-1:0] c_one      = c_idx_w'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [c_idx_w-1:0] r_win;
    logic [c_idx_w-1:0] w_win;
    logic               w_found;
    logic               r_we;
    logic               w_we_sel;
    logic [1:0]         r_cnt;
    logic [AW-1:0]      r_mem_addr;
    logic [AW-1:0]      w_addr;
    logic [DW-1:0]      r_mem_din;
    logic [DW-1:0]      w_wdata;
    logic [DW-1:0]      r_rdata;
    logic [NCH-1:0]     w_win_oh;

`ifdef MEM_ARB_RR_EN
    localparam logic [c_idx_w:0] c_nch = (c_idx_w + 1)'(NCH);

    logic [c_idx_w-1:0] r_ptr;
    logic [NCH-1:0]     w_rot;
    logic [c_idx_w-1:0] w_off;
    logic [c_idx_w:0]   w_sum;
    logic [c_idx_w:0]   w_wrap;

    // Rotate requests so the pointer position lands at bit 0, then pick the lowest
    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        w_rot   = NCH'({bus.req, bus.req} >> r_ptr);
        for (int k = NCH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = c_idx_w'(k);
            end
        end
        w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
        w_wrap = w_sum - c_nch;
        w_win  = (w_sum >= c_nch) ? w_wrap[c_idx_w-1:0] : w_sum[c_idx_w-1:0];
    end

    always_ff @(posedge F14Mx2 or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (r_state == S_DONE) begin
            r_ptr <= (r_win == c_last) ? '0 : r_win + c_one;
        end
    end
`else
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (bus.req[k]) begin
                w_found = 1'b1;
                w_win   = c_idx_w'(k);
            end
        end
    end
`endif

    always_comb begin
        w_addr   = '0;
        w_wdata  = '0;
        w_we_sel = 1'b0;
        w_win_oh = '0;
        for (int k = 0; k < NCH; k++) begin
            if (w_win == c_idx_w'(k)) begin
                w_addr   = bus.addr[k*AW +: AW];
                w_wdata  = bus.wdata[k*DW +: DW];
                w_we_sel = bus.we[k];
            end
            w_win_oh[k] = (r_win == c_idx_w'(k));
        end
    end

    always_ff @(posedge F14Mx2 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        bus.ack      = '0;
        bus.grant    = '0;
        bus.mem_we   = 1'b0;
        bus.mem_re   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.grant    = w_win_oh;
                bus.mem_we   = r_we;
                bus.mem_re   = !r_we;
                w_next_state = r_we ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                bus.grant = w_win_oh;
                if (r_cnt == 2'd0) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                bus.grant    = w_win_oh;
                bus.ack      = w_win_oh;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Transaction fields are latched only when leaving IDLE, so req changes later are ignored
    always_ff @(posedge F14Mx2 or posedge reset) begin
        if (reset) begin
            r_win      <= '0;
            r_we       <= 1'b0;
            r_cnt      <= 2'd0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_win      <= w_win;
                        r_we       <= w_we_sel;
                        r_mem_addr <= w_addr;
                        r_mem_din  <= w_wdata;
                    end
                end
                S_ISSUE: r_cnt <= c_cnt_init;
                S_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_rdata <= bus.mem_dout;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_din  = r_mem_din;
    assign bus.rdata    = r_rdata;
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed bench for mem_port_arbiter at RD_LAT=1 and RD_LAT=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    logic clk;
    logic rst_a;
    logic rst_b;

    mem_port_arbiter_if #(.NCH(3), .AW(25), .DW(8)) bus_a ();
    mem_port_arbiter_if #(.NCH(3), .AW(25), .DW(8)) bus_b ();

    mem_port_arbiter #(.NCH(3), .AW(25), .DW(8), .RD_LAT(1)) u_dut_a (
        .F14Mx2 (clk),
        .reset  (rst_a),
        .bus    (bus_a)
    );

    mem_port_arbiter #(.NCH(3), .AW(25), .DW(8), .RD_LAT(3)) u_dut_b (
        .F14Mx2 (clk),
        .reset  (rst_b),
        .bus    (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: data = 0xC3 ^ addr[23:16], valid only RD_LAT cycles after mem_re
    logic [7:0] r_pipe_a;
    logic [7:0] r_pipe_b [3];
    always @(posedge clk) begin
        r_pipe_a    <= bus_a.mem_re ? (8'hC3 ^ bus_a.mem_addr[23:16]) : 8'h00;
        r_pipe_b[0] <= bus_b.mem_re ? (8'hC3 ^ bus_b.mem_addr[23:16]) : 8'h00;
        r_pipe_b[1] <= r_pipe_b[0];
        r_pipe_b[2] <= r_pipe_b[1];
    end
    assign bus_a.mem_dout = r_pipe_a;
    assign bus_b.mem_dout = r_pipe_b[2];

    localparam logic [24:0] c_addr [3] = '{25'h0000100, 25'h0010000, 25'h0000200};
    localparam logic [7:0]  c_data [3] = '{8'h11, 8'h5A, 8'h33};

`ifdef MEM_ARB_RR_EN
    localparam logic [2:0] c_g13 = 3'b010, c_g16 = 3'b100, c_g19 = 3'b001,
                           c_g22 = 3'b010, c_g25 = 3'b100;
`else
    localparam logic [2:0] c_g13 = 3'b001, c_g16 = 3'b001, c_g19 = 3'b001,
                           c_g22 = 3'b001, c_g25 = 3'b010;
`endif

    typedef struct {
        logic [2:0] req;
        logic [2:0] we;
        logic [2:0] grant;
        logic [2:0] ack;
        logic       mwe;
        logic       mre;
        logic [7:0] rdata;
    } vec_t;

    vec_t tv [40];
    int   n_vec = 0;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic add(input logic [2:0] r, input logic [2:0] w, input logic [2:0] g,
                       input logic [2:0] a, input logic mw, input logic mr, input logic [7:0] rd);
        tv[n_vec] = '{req: r, we: w, grant: g, ack: a, mwe: mw, mre: mr, rdata: rd};
        n_vec++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        logic [24:0] w_exp_addr;
        logic [7:0]  w_exp_din;

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.req = '0; bus_a.we = '0;
        bus_b.req = '0; bus_b.we = '0;
        bus_a.addr  = {c_addr[2], c_addr[1], c_addr[0]};
        bus_b.addr  = {c_addr[2], c_addr[1], c_addr[0]};
        bus_a.wdata = {c_data[2], c_data[1], c_data[0]};
        bus_b.wdata = {c_data[2], c_data[1], c_data[0]};

        #1;
        chk("rst_grant", 32'(bus_a.grant), 0);
        chk("rst_ack", 32'(bus_a.ack), 0);
        chk("rst_strobes", {30'd0, bus_a.mem_we, bus_a.mem_re}, 0);
        chk("rst_mem_addr", 32'(bus_a.mem_addr), 0);
        chk("rst_mem_din", 32'(bus_a.mem_din), 0);
        chk("rst_rdata", 32'(bus_a.rdata), 0);
        chk("rst_b_grant", 32'(bus_b.grant), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // single write ch1, single read ch2
        add(3'b010, 3'b010, 3'b000, 3'b000, 0, 0, 8'h00);
        add(3'b010, 3'b010, 3'b010, 3'b000, 1, 0, 8'h00);
        add(3'b010, 3'b010, 3'b010, 3'b010, 0, 0, 8'h00);
        add(3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 8'h00);
        add(3'b100, 3'b000, 3'b000, 3'b000, 0, 0, 8'h00);
        add(3'b100, 3'b000, 3'b100, 3'b000, 0, 1, 8'h00);
        add(3'b100, 3'b000, 3'b100, 3'b000, 0, 0, 8'h00);
        add(3'b100, 3'b000, 3'b100, 3'b100, 0, 0, 8'hC3);
        add(3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 8'hC3);
        // contention: all three writing
        add(3'b111, 3'b111, 3'b000, 3'b000, 0, 0, 8'hC3);
        add(3'b111, 3'b111, 3'b001, 3'b000, 1, 0, 8'hC3);
        add(3'b111, 3'b111, 3'b001, 3'b001, 0, 0, 8'hC3);
        add(3'b111, 3'b111, 3'b000, 3'b000, 0, 0, 8'hC3);
        add(3'b111, 3'b111, c_g13,  3'b000, 1, 0, 8'hC3);
        add(3'b111, 3'b111, c_g13,  c_g13,  0, 0, 8'hC3);
        add(3'b111, 3'b111, 3'b000, 3'b000, 0, 0, 8'hC3);
        add(3'b111, 3'b111, c_g16,  3'b000, 1, 0, 8'hC3);
        add(3'b111, 3'b111, c_g16,  c_g16,  0, 0, 8'hC3);
        add(3'b111, 3'b111, 3'b000, 3'b000, 0, 0, 8'hC3);
        add(3'b111, 3'b111, c_g19,  3'b000, 1, 0, 8'hC3);
        add(3'b111, 3'b111, c_g19,  c_g19,  0, 0, 8'hC3);
        add(3'b111, 3'b111, 3'b000, 3'b000, 0, 0, 8'hC3);
        add(3'b111, 3'b111, c_g22,  3'b000, 1, 0, 8'hC3);
        add(3'b111, 3'b111, c_g22,  c_g22,  0, 0, 8'hC3);
        // ch0 drops, then ch1 drops after its turn
        add(3'b110, 3'b111, 3'b000, 3'b000, 0, 0, 8'hC3);
        add(3'b110, 3'b111, c_g25,  3'b000, 1, 0, 8'hC3);
        add(3'b110, 3'b111, c_g25,  c_g25,  0, 0, 8'hC3);
        add(3'b100, 3'b111, 3'b000, 3'b000, 0, 0, 8'hC3);
        add(3'b100, 3'b111, 3'b100, 3'b000, 1, 0, 8'hC3);
        add(3'b100, 3'b111, 3'b100, 3'b100, 0, 0, 8'hC3);
        add(3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 8'hC3);
        // ch1 read withdrawn during ISSUE still completes, once
        add(3'b010, 3'b000, 3'b000, 3'b000, 0, 0, 8'hC3);
        add(3'b000, 3'b000, 3'b010, 3'b000, 0, 1, 8'hC3);
        add(3'b000, 3'b000, 3'b010, 3'b000, 0, 0, 8'hC3);
        add(3'b000, 3'b000, 3'b010, 3'b010, 0, 0, 8'hC2);
        add(3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 8'hC2);
        add(3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 8'hC2);
        add(3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 8'hC2);

        for (int i = 0; i < n_vec; i++) begin
            @(negedge clk);
            bus_a.req = tv[i].req;
            bus_a.we  = tv[i].we;
            chk($sformatf("v%0d_grant", i), 32'(bus_a.grant), 32'(tv[i].grant));
            chk($sformatf("v%0d_ack", i), 32'(bus_a.ack), 32'(tv[i].ack));
            chk($sformatf("v%0d_mem_we", i), 32'(bus_a.mem_we), 32'(tv[i].mwe));
            chk($sformatf("v%0d_mem_re", i), 32'(bus_a.mem_re), 32'(tv[i].mre));
            chk($sformatf("v%0d_rdata", i), 32'(bus_a.rdata), 32'(tv[i].rdata));
            if (tv[i].mwe || tv[i].mre) begin
                w_exp_addr = '0;
                w_exp_din  = '0;
                for (int k = 0; k < 3; k++) begin
                    if (tv[i].grant[k]) begin
                        w_exp_addr = c_addr[k];
                        w_exp_din  = c_data[k];
                    end
                end
                chk($sformatf("v%0d_mem_addr", i), 32'(bus_a.mem_addr), 32'(w_exp_addr));
                if (tv[i].mwe) begin
                    chk($sformatf("v%0d_mem_din", i), 32'(bus_a.mem_din), 32'(w_exp_din));
                end
            end
        end
        chk("addr_hold_idle", 32'(bus_a.mem_addr), 32'(c_addr[1]));

        // RD_LAT=3 read on ch2: mem_re in cycle 1, ack+rdata in cycle 5
        @(negedge clk);
        bus_b.req = 3'b100;
        bus_b.we  = 3'b000;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 5) bus_b.req = 3'b000;
            chk($sformatf("lat3_c%0d_ack", c), 32'(bus_b.ack), (c == 5) ? 32'b100 : 32'b0);
            chk($sformatf("lat3_c%0d_mem_re", c), 32'(bus_b.mem_re), (c == 1) ? 32'd1 : 32'd0);
            if (c == 1) chk("lat3_mem_addr", 32'(bus_b.mem_addr), 32'(c_addr[2]));
            if (c == 5) chk("lat3_rdata", 32'(bus_b.rdata), 32'hC3);
        end

        // reset asserted while a ch1 read sits in WAIT
        @(negedge clk);
        bus_b.req = 3'b010;
        bus_b.we  = 3'b000;
        repeat (3) @(negedge clk);
        chk("pre_rst_in_wait", 32'(bus_b.grant), 32'b010);
        rst_b = 1'b1;
        bus_b.req = 3'b000;
        #1;
        chk("midrst_grant", 32'(bus_b.grant), 0);
        chk("midrst_ack", 32'(bus_b.ack), 0);
        chk("midrst_strobes", {30'd0, bus_b.mem_we, bus_b.mem_re}, 0);
        chk("midrst_mem_addr", 32'(bus_b.mem_addr), 0);
        chk("midrst_rdata", 32'(bus_b.rdata), 0);
        @(negedge clk);
        rst_b = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("postrst_c%0d_ack", c), 32'(bus_b.ack), 0);
            chk($sformatf("postrst_c%0d_grant", c), 32'(bus_b.grant), 0);
        end

        // fresh ch0 write after reset
        bus_b.req = 3'b001;
        bus_b.we  = 3'b001;
        @(negedge clk);
        chk("wr0_mem_we", 32'(bus_b.mem_we), 1);
        chk("wr0_mem_addr", 32'(bus_b.mem_addr), 32'(c_addr[0]));
        chk("wr0_mem_din", 32'(bus_b.mem_din), 32'(c_data[0]));
        @(negedge clk);
        bus_b.req = 3'b000;
        chk("wr0_ack", 32'(bus_b.ack), 32'b001);
        chk("wr0_rdata", 32'(bus_b.rdata), 0);
        @(negedge clk);
        chk("wr0_idle_grant", 32'(bus_b.grant), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
